// File: rtl/uart_receiver_if.sv
// UART receive-side signal bundle: serial line in, received byte and status out.
interface uart_receiver_if;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    // Line driver / consumer side.
    modport master (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  serial_in,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualification at half bit, single mid-bit sample per data bit,
// stop-bit check with one-cycle data_valid / framing_error pulses.
module uart_receiver #(
    parameter int unsigned CLOCKS_PER_BIT = 5000
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  uart
);
    localparam int unsigned HALF_BIT = CLOCKS_PER_BIT / 2;
    localparam int unsigned CW       = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            sync1_q, rx_s;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= uart.serial_in;
            rx_s    <= sync1_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, bit timing and output-pulse decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line that is high again at half bit was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                // Hold off until the line returns high so a break reports only once.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign uart.data_out      = data_q;
    assign uart.data_valid    = valid_q;
    assign uart.framing_error = ferr_q;
    assign uart.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed-frame bench for uart_receiver with a queue-based scoreboard and pulse monitor.
module tb_uart_receiver;
    localparam int unsigned CPB  = 8;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned LAT  = 2 + HALF + 9 * CPB;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    bit          prev_pulse = 1'b0;

    uart_receiver_if u_if();

    uart_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .reset(reset),
        .uart (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a pulse is presented.
    always @(negedge clk) begin
        bit   pulse;
        exp_t e;
        pulse = u_if.data_valid | u_if.framing_error;
        if (pulse) begin
            check("pulse_exclusive", {30'd0, u_if.data_valid & u_if.framing_error, prev_pulse},
                  32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, u_if.data_valid, u_if.framing_error}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {31'd0, u_if.framing_error}, {31'd0, e.is_err});
                check("data_out", {24'd0, u_if.data_out}, {24'd0, e.data});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
        prev_pulse = pulse;
    end

    task automatic hold_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; the first-flop low sample is the next edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_pulse,
                              input logic [7:0] exp_data);
        exp_t e;
        u_if.serial_in = 1'b0;
        if (expect_pulse) begin
            e.is_err = !stop_bit;
            e.data   = exp_data;
            e.cyc    = cyc + 1 + LAT;
            q.push_back(e);
        end
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            u_if.serial_in = b[i];
            hold_bit();
        end
        u_if.serial_in = stop_bit;
        hold_bit();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, {24'd0, u_if.data_out}, 32'd0);
        check({tag, "_data_valid"}, {31'd0, u_if.data_valid}, 32'd0);
        check({tag, "_framing_error"}, {31'd0, u_if.framing_error}, 32'd0);
        check({tag, "_busy"}, {31'd0, u_if.busy}, 32'd0);
    endtask

    initial begin
        int waited;
        reset          = 1'b1;
        u_if.serial_in = 1'b1;
        idle(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(4);

        // Good frame 0xA5.
        send_frame(8'hA5, 1'b1, 1'b1, 8'hA5);
        idle(4);

        // Two-cycle glitch is rejected.
        u_if.serial_in = 1'b0;
        idle(2);
        u_if.serial_in = 1'b1;
        idle(8);
        check("glitch_busy", {31'd0, u_if.busy}, 32'd0);
        check("glitch_data_out", {24'd0, u_if.data_out}, 32'hA5);

        // Good 0x11, then 0x3C with a low stop bit followed by a break.
        send_frame(8'h11, 1'b1, 1'b1, 8'h11);
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b1, 8'h11);
        idle(100);
        check("break_busy", {31'd0, u_if.busy}, 32'd1);
        check("break_data_out", {24'd0, u_if.data_out}, 32'h11);
        u_if.serial_in = 1'b1;
        idle(4);
        check("after_break_busy", {31'd0, u_if.busy}, 32'd0);
        idle(4);

        // Reset at edge T+40 of a 0x5A frame; held until the frame is over.
        fork
            send_frame(8'h5A, 1'b1, 1'b0, 8'h00);
            begin
                repeat (41) @(posedge clk);
                #1;
                reset = 1'b1;
                #1;
                check_reset_outputs("midframe_reset");
            end
        join
        idle(2);
        reset = 1'b0;
        idle(4);
        check("post_reset_busy", {31'd0, u_if.busy}, 32'd0);
        check("post_reset_data_out", {24'd0, u_if.data_out}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b1, 8'h81);
        idle(4);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 1'b1, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b1, 8'hFF);

        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            idle(1);
            waited++;
        end
        check("scoreboard_drained", q.size(), 32'd0);
        idle(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
